serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial-to-parallel receiver for the tick-paced single-bit delay-line stream. It samples a serial line only on clock-enable ticks and frames data as start bit, WIDTH data bits LSB-first, then stop bit. Completed words are presented on a valid/ready handshake. Framing and overrun errors are reported as one-cycle pulses. It sits downstream of the `clock_en` tick generator and consumes the `dout`/`doutf` output of the shift-register FSM.

## Interface
- `WIDTH`, default 8: data bits per frame. Legal range is 2..32.
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `tick_en`  input  1  one-`clk` sampling strobe from `clock_en`; `sdin` is sampled only when it is high.
- `sdin`  input  1  serial line; idles at 1.
- `word`  output  WIDTH  received data; stable while `word_valid` is high.
- `word_valid`  output  1  a word is held for the consumer.
- `word_ready`  input  1  consumer accepts `word` when `word_valid && word_ready`.
- `frame_err`  output  1  one-`clk` pulse: stop bit sampled as 0.
- `overrun`  output  1  one-`clk` pulse: a frame completed while the held word was not being accepted.
- `busy`  output  1  high in every state except IDLE.

## Operation
- **State machine:** four states, IDLE, DATA, STOP and BREAK. State transitions occur only on `clk` edges with `tick_en=1`. When `tick_en=0`, state, the bit counter and the shift register all hold.
- **IDLE:** on a tick with `sdin=0`, go to DATA and clear the bit counter. On a tick with `sdin=1`, stay in IDLE.
- **DATA:** on each tick, shift `sdin` into `shreg[WIDTH-1]` and shift right, so data arrives LSB-first. Increment the counter. After the tick where counter == WIDTH-1, go to STOP.
  - The counter is `$clog2(WIDTH)` bits wide and never wraps inside a frame.
- **STOP, tick with `sdin=1`:** the frame is complete.
  - If `word_valid=0`, or `word_ready=1` in the same cycle: load `word <= shreg` and set `word_valid=1`.
  - Otherwise: drop the new word, pulse `overrun`, and leave `word`/`word_valid` unchanged.
  - Go to IDLE in either case.
- **STOP, tick with `sdin=0`:** pulse `frame_err`, discard `shreg`, go to BREAK.
- **BREAK:** stay until a tick samples `sdin=1`, then go to IDLE. A line held low is never taken as a new start bit.
- **Handshake:**
  - `word_valid` clears on the `clk` edge where `word_valid && word_ready` is high. This does not depend on `tick_en`.
  - `word` never changes while `word_valid=1` unless that same cycle is an accept.
  - If an accept and a frame completion land on the same edge, the new word is loaded, `word_valid` stays 1, and `overrun` stays 0.
- **Reset:** `rst` takes priority over everything, including a coincident tick. Every register returns to its reset value on the next `clk` edge, which aborts any frame in progress.

## Timing
- **Reset values:** `word=0`, `word_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`; state IDLE, counter 0, `shreg=0`.
- **Latency:** `word_valid` rises on the same `clk` edge as the tick that samples a good stop bit. That is WIDTH+1 ticks after the start-bit tick.
- **Error pulses:** `frame_err` and `overrun` are registered and high for exactly one `clk` cycle, on the edge of the offending stop-bit tick.
- **`busy`:** rises on the start-bit tick edge. It falls on the stop-bit tick edge, or on the BREAK exit edge.
- **Back-to-back frames:** a start bit sampled on the tick immediately after the stop tick is accepted, so there is no inter-frame gap requirement.
- **Tick spacing:** minimum spacing between ticks is 1 `clk`; `tick_en` may be held high continuously.
- **Consumer stall:** `word_ready` may stay low indefinitely. The design has no timeout.

## Test plan
- **Good frame:** WIDTH=8, `tick_en` every 4 clk, frame is start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, with `word_ready=1`.
  - Required: `word=0xA5`, `word_valid` high for 1 cycle, starting on the 10th tick edge; `busy` high for ticks 1–10.
- **Framing error:** same frame but stop bit = 0, then line held low 3 ticks, then high.
  - Required: `frame_err` pulses once, `word_valid` stays 0.
  - Required: while the line is held low, no new frame starts and `busy` stays high; IDLE is reached on the first high tick.
- **Overrun:** `word_ready=0`, send 0x3C then 0xC3.
  - Required: `word` stays 0x3C, `word_valid` stays 1, and `overrun` pulses at the second stop tick.
  - Then assert `word_ready` for 1 cycle. Required: `word_valid` falls.
- **Simultaneous accept and completion:** hold 0x11 with `word_valid=1`, and assert `word_ready` exactly on the stop tick of 0x22.
  - Required: `word=0x22`, `word_valid=1`, `overrun=0`.
- **Reset mid-frame:** assert `rst` for 1 clk after 4 data bits, with `tick_en` high in the same cycle.
  - Required: all outputs 0 and state IDLE on the next edge.
  - Then a full frame with data bits all 1 (0xFF). Required: it is received as 0xFF.
- **`tick_en` held high and WIDTH=2:** back-to-back frames 0b01 and 0b10 with no gap.
  - Required: two accepted words, 0x1 then 0x2, each with `word_valid` asserted for one cycle.

Source files
------------

// File: rtl/serial_word_rx_if.sv
// Handshake and serial-line bundle between the tick-paced line source,
// the word receiver and its downstream consumer.
interface serial_word_rx_if #(
    parameter int WIDTH = 8
);
    logic             tick_en;
    logic             sdin;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    // The master side feeds the line and consumes words.
    modport master (
        output tick_en, sdin, word_ready,
        input  word, word_valid, frame_err, overrun, busy
    );

    modport slave (
        input  tick_en, sdin, word_ready,
        output word, word_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_word_rx.sv
// Tick-sampled serial receiver: start bit, WIDTH data bits LSB-first, and a
// stop bit, with completed words handed off on a valid/ready port.
module serial_word_rx #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_word_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] shReg_q, shReg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             wordValid_q, wordValid_d;
    logic             frameErr_q, frameErr_d;
    logic             overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shReg_q     <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shReg_q     <= shReg_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            frameErr_q  <= frameErr_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shReg_d     = shReg_q;
        word_d      = word_q;
        // An accept clears the held word regardless of tick timing.
        wordValid_d = wordValid_q && !bus.word_ready;
        frameErr_d  = 1'b0;
        overrun_d   = 1'b0;

        if (bus.tick_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.sdin) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shReg_d = {bus.sdin, shReg_q[WIDTH-1:1]};
                    if (bitCnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bus.sdin) begin
                        // A same-edge accept frees the slot for the new word.
                        if (!wordValid_q || bus.word_ready) begin
                            word_d      = shReg_q;
                            wordValid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        shReg_d    = '0;
                        state_d    = BREAK;
                    end
                end
                BREAK: begin
                    if (bus.sdin) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = wordValid_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: an 8-bit receiver paced every 4 clk and
// a 2-bit receiver with tick_en held high.
module tb_serial_word_rx;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_word_rx_if #(.WIDTH(8)) bus8 ();
    serial_word_rx_if #(.WIDTH(2)) bus2 ();

    serial_word_rx #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_word_rx #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleClocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick on the 8-bit receiver; returns just after the sampling edge.
    task automatic applyStimulus(input logic b);
        bus8.sdin    = b;
        bus8.tick_en = 1'b1;
        @(posedge clk);
        #1;
        bus8.tick_en = 1'b0;
        bus8.sdin    = 1'b1;
    endtask

    // Returns right after the stop-bit tick edge.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input logic stopReady);
        applyStimulus(1'b0);
        checkOutput("busy_on_start", {31'b0, bus8.busy}, 32'd1);
        idleClocks(3);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(data[i]);
            idleClocks(3);
        end
        bus8.word_ready = stopReady;
        applyStimulus(stopBit);
    endtask

    logic seq2   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic valid2 [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int pulses;
        rst             = 1'b1;
        bus8.tick_en    = 1'b0;
        bus8.sdin       = 1'b1;
        bus8.word_ready = 1'b0;
        bus2.tick_en    = 1'b0;
        bus2.sdin       = 1'b1;
        bus2.word_ready = 1'b0;
        idleClocks(2);
        checkOutput("rst_word",      {24'b0, bus8.word},       32'h0);
        checkOutput("rst_valid",     {31'b0, bus8.word_valid}, 32'd0);
        checkOutput("rst_frame_err", {31'b0, bus8.frame_err},  32'd0);
        checkOutput("rst_overrun",   {31'b0, bus8.overrun},    32'd0);
        checkOutput("rst_busy",      {31'b0, bus8.busy},       32'd0);
        rst = 1'b0;
        idleClocks(2);

        $display("[TB] good frame 0xA5");
        bus8.word_ready = 1'b1;
        sendFrame(8'hA5, 1'b1, 1'b1);
        checkOutput("good_word",  {24'b0, bus8.word},       32'hA5);
        checkOutput("good_valid", {31'b0, bus8.word_valid}, 32'd1);
        checkOutput("good_busy",  {31'b0, bus8.busy},       32'd0);
        idleClocks(1);
        checkOutput("good_valid_drop", {31'b0, bus8.word_valid}, 32'd0);
        idleClocks(2);

        $display("[TB] framing error");
        sendFrame(8'hA5, 1'b0, 1'b1);
        checkOutput("ferr_pulse", {31'b0, bus8.frame_err},  32'd1);
        checkOutput("ferr_valid", {31'b0, bus8.word_valid}, 32'd0);
        checkOutput("ferr_busy",  {31'b0, bus8.busy},       32'd1);
        idleClocks(1);
        checkOutput("ferr_pulse_end", {31'b0, bus8.frame_err}, 32'd0);
        idleClocks(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0);
            checkOutput("break_busy", {31'b0, bus8.busy}, 32'd1);
            idleClocks(3);
        end
        applyStimulus(1'b1);
        checkOutput("break_exit_busy",  {31'b0, bus8.busy},       32'd0);
        checkOutput("break_exit_valid", {31'b0, bus8.word_valid}, 32'd0);
        idleClocks(3);

        $display("[TB] overrun");
        bus8.word_ready = 1'b0;
        sendFrame(8'h3C, 1'b1, 1'b0);
        checkOutput("ovr_first_word",  {24'b0, bus8.word},       32'h3C);
        checkOutput("ovr_first_valid", {31'b0, bus8.word_valid}, 32'd1);
        idleClocks(3);
        sendFrame(8'hC3, 1'b1, 1'b0);
        checkOutput("ovr_pulse", {31'b0, bus8.overrun},    32'd1);
        checkOutput("ovr_word",  {24'b0, bus8.word},       32'h3C);
        checkOutput("ovr_valid", {31'b0, bus8.word_valid}, 32'd1);
        idleClocks(1);
        checkOutput("ovr_pulse_end", {31'b0, bus8.overrun}, 32'd0);
        bus8.word_ready = 1'b1;
        idleClocks(1);
        bus8.word_ready = 1'b0;
        checkOutput("ovr_accept", {31'b0, bus8.word_valid}, 32'd0);
        idleClocks(2);

        $display("[TB] accept coincident with completion");
        sendFrame(8'h11, 1'b1, 1'b0);
        checkOutput("sim_hold_word", {24'b0, bus8.word}, 32'h11);
        idleClocks(3);
        sendFrame(8'h22, 1'b1, 1'b1);
        bus8.word_ready = 1'b0;
        checkOutput("sim_word",    {24'b0, bus8.word},       32'h22);
        checkOutput("sim_valid",   {31'b0, bus8.word_valid}, 32'd1);
        checkOutput("sim_overrun", {31'b0, bus8.overrun},    32'd0);
        bus8.word_ready = 1'b1;
        idleClocks(1);
        checkOutput("sim_accept", {31'b0, bus8.word_valid}, 32'd0);
        idleClocks(2);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0);
        idleClocks(3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1);
            idleClocks(3);
        end
        rst          = 1'b1;
        bus8.tick_en = 1'b1;
        bus8.sdin    = 1'b0;
        idleClocks(1);
        rst          = 1'b0;
        bus8.tick_en = 1'b0;
        bus8.sdin    = 1'b1;
        checkOutput("mid_rst_word",  {24'b0, bus8.word},       32'h0);
        checkOutput("mid_rst_valid", {31'b0, bus8.word_valid}, 32'd0);
        checkOutput("mid_rst_busy",  {31'b0, bus8.busy},       32'd0);
        checkOutput("mid_rst_ferr",  {31'b0, bus8.frame_err},  32'd0);
        idleClocks(2);
        sendFrame(8'hFF, 1'b1, 1'b1);
        checkOutput("after_rst_word",  {24'b0, bus8.word},       32'hFF);
        checkOutput("after_rst_valid", {31'b0, bus8.word_valid}, 32'd1);
        idleClocks(2);

        $display("[TB] WIDTH=2 back-to-back with tick_en held high");
        pulses          = 0;
        bus2.word_ready = 1'b1;
        bus2.tick_en    = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus2.sdin = seq2[k];
            idleClocks(1);
            checkOutput("w2_valid", {31'b0, bus2.word_valid}, {31'b0, valid2[k]});
            if (bus2.word_valid) pulses++;
            if (k == 3) checkOutput("w2_word_first",  {30'b0, bus2.word}, 32'h1);
            if (k == 7) checkOutput("w2_word_second", {30'b0, bus2.word}, 32'h2);
        end
        bus2.tick_en = 1'b0;
        checkOutput("w2_pulse_count", pulses, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
